// File: rtl/spi_controller_if.sv
// Parallel request/response bus between a register-programming client and spi_controller.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, done, rdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, done, rdata
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises 16-bit {rw, addr, data} frames MSB first.
// Optional readback of cipo into rdata is enabled by defining SPI_CTRL_READBACK_EN.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             sclk,
  output logic             copi,
  output logic             ncs,
  input  logic             cipo
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] CNT_DONE = 8'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;
  logic        last_phase;

  assign last_phase    = (cnt_q == CNT_LAST);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign sclk          = sclk_q;
  assign copi          = copi_q;
  assign ncs           = ncs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = last_phase ? 8'd0 : cnt_q + 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (bus.req_valid) begin
          shift_d = {bus.req_rw, bus.req_addr, bus.req_data};
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = 8'd0;
        bit_d   = 5'd0;
        ncs_d   = 1'b0;
        copi_d  = shift_q[15];
        state_d = SETUP;
      end
      SETUP: begin
        if (last_phase) begin
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (last_phase) begin
          bit_d  = bit_q + 5'd1;
          sclk_d = 1'b0;
          if (bit_q == 5'd15) begin
            state_d = HOLD;
          end else begin
            // Next bit is presented on the falling edge so it is stable at the next rise.
            shift_d = {shift_q[14:0], 1'b0};
            copi_d  = shift_q[14];
            state_d = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: begin
        if (last_phase) begin
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end
      HOLD: begin
        if (last_phase) begin
          ncs_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        // Registered so done lands exactly in the final GAP cycle.
        done_d = (cnt_q == CNT_DONE);
        if (last_phase) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [15:0] rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;

  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (sclk_d && !sclk_q) rx_d = {rx_q[14:0], cipo};
    if (done_d) rdata_d = rx_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q    <= 16'd0;
      rdata_q <= 8'd0;
    end else begin
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
`else
  wire cipo_unused = cipo;
  assign bus.rdata = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 16'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
    end
  end

endmodule
